// File: rtl/accu_cpu.sv
// Parametrised accumulator processor core with handshaked instruction fetch,
// handshaked data memory with wait states, conditional branching and a halt state.
module accu_cpu #(
    parameter int DATA_W    = 8,
    parameter int REG_DEPTH = 16,
    parameter int PC_W      = 6,
    parameter int INS_W     = 4 + DATA_W
) (
    input  logic              clk,
    input  logic              Reset,
    output logic [PC_W-1:0]   InsAddr,
    output logic              InsReq,
    input  logic [INS_W-1:0]  InsData,
    input  logic              InsValid,
    output logic [DATA_W-1:0] DmAddr,
    output logic [DATA_W-1:0] DmWData,
    input  logic [DATA_W-1:0] DmRData,
    output logic              DmReq,
    output logic              DmWe,
    input  logic              DmAck,
    output logic [DATA_W-1:0] Accu,
    output logic              Carry,
    output logic              Retire,
    output logic              Halted
);

    localparam int RI_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_MEM   = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_LDR  = 4'd2;
    localparam logic [3:0] OP_STR  = 4'd3;
    localparam logic [3:0] OP_LDM  = 4'd4;
    localparam logic [3:0] OP_STM  = 4'd5;
    localparam logic [3:0] OP_ADD  = 4'd6;
    localparam logic [3:0] OP_ADC  = 4'd7;
    localparam logic [3:0] OP_SUB  = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_OR   = 4'd10;
    localparam logic [3:0] OP_XOR  = 4'd11;
    localparam logic [3:0] OP_ADDI = 4'd12;
    localparam logic [3:0] OP_JMP  = 4'd13;
    localparam logic [3:0] OP_JZ   = 4'd14;
    localparam logic [3:0] OP_HLT  = 4'd15;

    localparam logic [PC_W-1:0] PC_ONE = 1;

    logic [1:0]        state, state_n;
    logic [PC_W-1:0]   pc, pc_n, pc_inc, pc_tgt;
    logic [DATA_W-1:0] a, a_n;
    logic              c, c_n;
    logic [INS_W-1:0]  ir, ir_n;
    logic              reg_we;
    logic [DATA_W-1:0] regs [REG_DEPTH];

    logic [3:0]        op;
    logic [DATA_W-1:0] imm;
    logic [RI_W-1:0]   ridx;
    logic [DATA_W-1:0] rd;
    logic              is_mem;

    assign op     = ir[INS_W-1:DATA_W];
    assign imm    = ir[DATA_W-1:0];
    assign ridx   = imm[RI_W-1:0];
    assign rd     = regs[ridx];
    assign is_mem = (op == OP_LDM) || (op == OP_STM);
    assign pc_inc = pc + PC_ONE;
    assign pc_tgt = imm[PC_W-1:0];

    always_comb begin
        state_n = state;
        pc_n    = pc;
        a_n     = a;
        c_n     = c;
        ir_n    = ir;
        reg_we  = 1'b0;
        case (state)
            ST_FETCH: begin
                if (InsValid) begin
                    ir_n    = InsData;
                    state_n = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_n = ST_FETCH;
                pc_n    = pc_inc;
                case (op)
                    OP_LDI:  a_n = imm;
                    OP_LDR:  a_n = rd;
                    OP_STR:  reg_we = 1'b1;
                    OP_LDM, OP_STM: begin
                        state_n = ST_MEM;
                        pc_n    = pc;
                    end
                    OP_ADD:  {c_n, a_n} = {1'b0, a} + {1'b0, rd};
                    OP_ADC:  {c_n, a_n} = {1'b0, a} + {1'b0, rd} + {{DATA_W{1'b0}}, c};
                    // The borrow lands in the extra top bit of the widened difference.
                    OP_SUB:  {c_n, a_n} = {1'b0, a} - {1'b0, rd};
                    OP_AND:  a_n = a & rd;
                    OP_OR:   a_n = a | rd;
                    OP_XOR:  a_n = a ^ rd;
                    OP_ADDI: {c_n, a_n} = {1'b0, a} + {1'b0, imm};
                    OP_JMP:  pc_n = pc_tgt;
                    OP_JZ:   if (a == '0) pc_n = pc_tgt;
                    OP_HLT: begin
                        state_n = ST_HALT;
                        pc_n    = pc;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                if (DmAck) begin
                    state_n = ST_FETCH;
                    pc_n    = pc_inc;
                    if (op == OP_LDM) a_n = DmRData;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_FETCH;
            pc    <= '0;
            a     <= '0;
            c     <= 1'b0;
            ir    <= '0;
            for (int unsigned i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            a     <= a_n;
            c     <= c_n;
            ir    <= ir_n;
            if (reg_we) regs[ridx] <= a;
        end
    end

    // Requests come from registered state only; Retire on a memory op follows DmAck.
    assign InsAddr = pc;
    assign InsReq  = (state == ST_FETCH);
    assign DmReq   = (state == ST_MEM);
    assign DmWe    = (state == ST_MEM) && (op == OP_STM);
    assign DmAddr  = imm;
    assign DmWData = a;
    assign Accu    = a;
    assign Carry   = c;
    assign Retire  = ((state == ST_EXEC) && !is_mem) || ((state == ST_MEM) && DmAck);
    assign Halted  = (state == ST_HALT);

endmodule

// File: tb/tb_accu_cpu.sv
// Self-checking bench for accu_cpu: ALU vector table, hand-written timing sequences
// and a randomized program run against an instruction-level reference model.
module tb_accu_cpu;

    logic        clk = 1'b0;
    logic        Reset;
    logic [5:0]  InsAddr;
    logic        InsReq;
    logic [11:0] InsData;
    logic        InsValid;
    logic [7:0]  DmAddr;
    logic [7:0]  DmWData;
    logic [7:0]  DmRData;
    logic        DmReq;
    logic        DmWe;
    logic        DmAck;
    logic [7:0]  Accu;
    logic        Carry;
    logic        Retire;
    logic        Halted;

    accu_cpu #(.DATA_W(8), .REG_DEPTH(16), .PC_W(6), .INS_W(12)) dut (
        .clk(clk), .Reset(Reset), .InsAddr(InsAddr), .InsReq(InsReq),
        .InsData(InsData), .InsValid(InsValid), .DmAddr(DmAddr), .DmWData(DmWData),
        .DmRData(DmRData), .DmReq(DmReq), .DmWe(DmWe), .DmAck(DmAck),
        .Accu(Accu), .Carry(Carry), .Retire(Retire), .Halted(Halted)
    );

    always #5 clk = ~clk;

    logic [11:0] imem [64];
    logic [7:0]  dmem [256];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc;
    int fetch_stall = 0;
    int mem_wait = 0;
    bit rnd_mode = 0;
    bit ret;
    int rq[$];

    // reference architectural state
    int mpc, ma, mc;
    int mr [16];
    int mdm [256];

    typedef struct {
        int op; int imm; int a0; int rv; int c0; int ea; int ec;
    } vec_t;
    vec_t tv [14];

    function automatic logic [11:0] ins(int op, int imm);
        logic [3:0] o;
        logic [7:0] i;
        o = op[3:0];
        i = imm[7:0];
        return {o, i};
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        InsData = imem[InsAddr];
        InsValid = 1'b0;
        if (InsReq) begin
            if (fetch_stall > 0) fetch_stall--;
            else InsValid = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        DmRData = dmem[DmAddr];
        DmAck = 1'b0;
        if (DmReq) begin
            if (mem_wait > 0) mem_wait--;
            else DmAck = rnd_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
        #1;
        ret = Retire;
        if (DmReq && DmAck && DmWe) dmem[DmAddr] = DmWData;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step(string nm);
        int k = 0;
        ret = 0;
        while (!ret && k < 60) begin
            cycle();
            k++;
        end
        if (!ret) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        InsValid = 1'b0;
        DmAck = 1'b0;
        InsData = '0;
        DmRData = '0;
        fetch_stall = 0;
        mem_wait = 0;
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b0;
        cyc = 1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = ins(0, 0);
    endtask

    task automatic model_exec();
        int op, imm, ri, t;
        op = int'(imem[mpc][11:8]);
        imm = int'(imem[mpc][7:0]);
        ri = imm % 16;
        mpc = (mpc + 1) % 64;
        case (op)
            1: ma = imm;
            2: ma = mr[ri];
            3: mr[ri] = ma;
            4: ma = mdm[imm];
            5: mdm[imm] = ma;
            6: begin t = ma + mr[ri]; ma = t % 256; mc = (t > 255) ? 1 : 0; end
            7: begin t = ma + mr[ri] + mc; ma = t % 256; mc = (t > 255) ? 1 : 0; end
            8: begin mc = (ma < mr[ri]) ? 1 : 0; ma = (ma - mr[ri] + 256) % 256; end
            9: ma = ma & mr[ri];
            10: ma = ma | mr[ri];
            11: ma = ma ^ mr[ri];
            12: begin t = ma + imm; ma = t % 256; mc = (t > 255) ? 1 : 0; end
            13: mpc = imm % 64;
            14: if (ma == 0) mpc = imm % 64;
            default: ;
        endcase
    endtask

    initial begin
        //        op  imm   a0    rv    c0 ea    ec
        tv[0]  = '{6,  1,   8'h01, 8'hFF, 0, 8'h00, 1};
        tv[1]  = '{6,  1,   8'h10, 8'h20, 1, 8'h30, 0};
        tv[2]  = '{7,  1,   8'h00, 8'hFF, 1, 8'h00, 1};
        tv[3]  = '{7,  1,   8'h10, 8'h20, 1, 8'h31, 0};
        tv[4]  = '{8,  1,   8'h03, 8'h05, 0, 8'hFE, 1};
        tv[5]  = '{8,  1,   8'h05, 8'h03, 1, 8'h02, 0};
        tv[6]  = '{8,  1,   8'h05, 8'h05, 1, 8'h00, 0};
        tv[7]  = '{9,  1,   8'hF0, 8'h3C, 1, 8'h30, 1};
        tv[8]  = '{10, 1,   8'hF0, 8'h0F, 0, 8'hFF, 0};
        tv[9]  = '{11, 1,   8'hFF, 8'h0F, 1, 8'hF0, 1};
        tv[10] = '{12, 8'h01, 8'hFF, 8'h00, 0, 8'h00, 1};
        tv[11] = '{12, 8'h03, 8'h05, 8'h00, 1, 8'h08, 0};
        tv[12] = '{2,  1,   8'h11, 8'h77, 1, 8'h77, 1};
        tv[13] = '{0,  1,   8'h42, 8'h00, 1, 8'h42, 1};

        for (int i = 0; i < 256; i++) dmem[i] = '0;
        clear_imem();

        // reset state
        do_reset();
        chk("rst_insaddr", InsAddr, 0);
        chk("rst_insreq", InsReq, 1);
        chk("rst_dmreq", DmReq, 0);
        chk("rst_dmwe", DmWe, 0);
        chk("rst_dmaddr", DmAddr, 0);
        chk("rst_dmwdata", DmWData, 0);
        chk("rst_accu", Accu, 0);
        chk("rst_carry", Carry, 0);
        chk("rst_retire", Retire, 0);
        chk("rst_halted", Halted, 0);

        // zero-wait LDI 5; ADDI 3; HLT
        imem[0] = ins(1, 5);
        imem[1] = ins(12, 3);
        imem[2] = ins(15, 0);
        do_reset();
        rq.delete();
        for (int k = 0; k < 10; k++) begin
            int cnow;
            cnow = cyc;
            cycle();
            if (ret) rq.push_back(cnow);
            if (cnow == 4) begin
                chk("prog_accu", Accu, 8);
                chk("prog_carry", Carry, 0);
            end
        end
        chk("prog_nretire", rq.size(), 3);
        if (rq.size() == 3) begin
            chk("prog_ret0", rq[0], 2);
            chk("prog_ret1", rq[1], 4);
            chk("prog_ret2", rq[2], 6);
        end
        chk("prog_halted", Halted, 1);
        chk("prog_halt_insreq", InsReq, 0);
        chk("prog_halt_dmreq", DmReq, 0);

        // ALU vector table
        for (int v = 0; v < 14; v++) begin
            int k;
            clear_imem();
            imem[0] = ins(1, tv[v].rv);
            imem[1] = ins(3, 1);
            imem[2] = ins(1, tv[v].c0 ? 8'hFF : 8'h00);
            imem[3] = ins(12, tv[v].c0);
            imem[4] = ins(1, tv[v].a0);
            imem[5] = ins(tv[v].op, tv[v].imm);
            imem[6] = ins(15, 0);
            do_reset();
            k = 0;
            while (!Halted && k < 40) begin
                cycle();
                k++;
            end
            chk($sformatf("vec%0d_halt", v), Halted, 1);
            chk($sformatf("vec%0d_accu", v), Accu, tv[v].ea);
            chk($sformatf("vec%0d_carry", v), Carry, tv[v].ec);
        end

        // PC wrap and branches
        clear_imem();
        imem[0] = ins(13, 8'h7F);
        imem[63] = ins(0, 0);
        do_reset();
        step("jmp");
        chk("jmp_7f_addr", InsAddr, 8'h3F);
        step("nop63");
        chk("wrap_addr", InsAddr, 0);
        imem[0] = ins(1, 0);
        imem[1] = ins(14, 10);
        imem[10] = ins(1, 1);
        imem[11] = ins(14, 10);
        imem[12] = ins(15, 0);
        step("ldi0");
        step("jz_taken");
        chk("jz_taken_addr", InsAddr, 10);
        step("ldi1");
        step("jz_not");
        chk("jz_not_addr", InsAddr, 12);
        step("hlt");
        chk("br_halted", Halted, 1);

        // fetch stall, then STM with wait states, then LDM
        clear_imem();
        imem[0] = ins(1, 8'h5A);
        imem[1] = ins(5, 8'h20);
        imem[2] = ins(1, 0);
        imem[3] = ins(4, 8'h20);
        imem[4] = ins(15, 0);
        do_reset();
        step("ldi5a");
        fetch_stall = 5;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_retire", ret, 0);
            chk("stall_insreq", InsReq, 1);
            chk("stall_insaddr", InsAddr, 1);
            chk("stall_accu", Accu, 8'h5A);
            chk("stall_carry", Carry, 0);
        end
        begin
            int nmem, nret, k;
            nmem = 0;
            nret = 0;
            k = 0;
            mem_wait = 3;
            while (nret == 0 && k < 20) begin
                if (DmReq) begin
                    nmem++;
                    chk("stm_dmwe", DmWe, 1);
                    chk("stm_dmaddr", DmAddr, 8'h20);
                    chk("stm_dmwdata", DmWData, 8'h5A);
                end
                cycle();
                if (ret) nret++;
                k++;
            end
            chk("stm_mem_cycles", nmem, 4);
            chk("stm_retires", nret, 1);
            chk("stm_dmreq_after", DmReq, 0);
        end
        chk("stm_written", dmem[8'h20], 8'h5A);
        step("ldi0b");
        chk("ldi0_accu", Accu, 0);
        step("ldm");
        chk("ldm_accu", Accu, 8'h5A);
        chk("ldm_insaddr", InsAddr, 4);

        // reset abandoned mid-MEM
        clear_imem();
        imem[0] = ins(1, 8'hFF);
        imem[1] = ins(3, 1);
        imem[2] = ins(12, 1);
        imem[3] = ins(1, 8'h33);
        imem[4] = ins(5, 8'h10);
        do_reset();
        for (int k = 0; k < 4; k++) step("pre");
        chk("pre_carry", Carry, 1);
        chk("pre_accu", Accu, 8'h33);
        mem_wait = 1000;
        repeat (5) cycle();
        chk("hang_dmreq", DmReq, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_dmreq", DmReq, 0);
        chk("async_retire", Retire, 0);
        chk("async_insreq", InsReq, 1);
        chk("async_halted", Halted, 0);
        @(posedge clk);
        #1;
        Reset = 1'b0;
        mem_wait = 0;
        DmAck = 1'b0;
        cyc = 1;
        chk("post_insaddr", InsAddr, 0);
        chk("post_accu", Accu, 0);
        chk("post_carry", Carry, 0);
        imem[0] = ins(2, 1);
        imem[1] = ins(15, 0);
        step("ldr1");
        chk("post_r1", Accu, 0);
        step("hlt2");
        chk("post_halted", Halted, 1);

        // randomized program against reference model
        for (int i = 0; i < 64; i++) imem[i] = ins($urandom_range(0, 14), $urandom_range(0, 255));
        for (int i = 0; i < 256; i++) begin
            dmem[i] = 8'($urandom_range(0, 255));
            mdm[i] = int'(dmem[i]);
        end
        for (int i = 0; i < 16; i++) mr[i] = 0;
        mpc = 0;
        ma = 0;
        mc = 0;
        do_reset();
        rnd_mode = 1;
        begin
            int f0;
            f0 = n_fail;
            for (int n = 0; n < 300 && n_fail == f0; n++) begin
                step("rnd");
                model_exec();
                chk($sformatf("rnd%0d_accu", n), Accu, ma);
                chk($sformatf("rnd%0d_carry", n), Carry, mc);
                chk($sformatf("rnd%0d_pc", n), InsAddr, mpc);
            end
        end
        rnd_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
